// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD parallel write bus.
package lcd_pkg;

    localparam int unsigned LCD_DATA_W = 8;

    localparam logic LCD_CD_CMD  = 1'b0;
    localparam logic LCD_CD_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_RECOVER = 2'd2
    } lcd_state_e;

    typedef struct packed {
        logic                  cd;
        logic [LCD_DATA_W-1:0] data;
    } lcd_byte_t;

endpackage

// File: rtl/lcd_bus_strobe.sv
// Write-strobe sequencer: one start launches WR_ACTIVE high cycles of lcd_write
// followed by WR_RECOVER low cycles before the bus returns to idle.
module lcd_bus_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned WR_ACTIVE  = 1,
    parameter int unsigned WR_RECOVER = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic lcd_write,
    output logic idle
);

    localparam int unsigned CNT_MAX = (WR_ACTIVE > WR_RECOVER) ? WR_ACTIVE : WR_RECOVER;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ACTIVE_LOAD  = CNT_W'(WR_ACTIVE - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'((WR_RECOVER > 0) ? WR_RECOVER - 1 : 0);

    lcd_state_e       state;
    lcd_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             write_nxt;

    // State, phase counter and strobe register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lcd_write <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lcd_write <= write_nxt;
        end
    end

    // Next state: counter holds remaining cycles of the current phase minus one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_STROBE;
                    cnt_nxt   = ACTIVE_LOAD;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    if (WR_RECOVER == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RECOVER;
                        cnt_nxt   = RECOVER_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: strobe is registered from the next state so it rises the cycle after start
    always_comb begin
        write_nxt = (state_nxt == ST_STROBE);
        idle      = (state == ST_IDLE);
    end

endmodule

// File: rtl/lcd_bus_arb.sv
// Pixel/command arbiter for the 8-bit LCD write bus: atomic command bursts,
// pixel priority bounded by a saturating run counter, bus data/cd registers.
module lcd_bus_arb
    import lcd_pkg::*;
#(
    parameter int unsigned WR_ACTIVE    = 1,
    parameter int unsigned WR_RECOVER   = 1,
    parameter int unsigned MAX_PX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  px_valid,
    input  logic [LCD_DATA_W-1:0] px_data,
    output logic                  px_ready,
    input  logic                  cmd_valid,
    input  logic [LCD_DATA_W-1:0] cmd_data,
    input  logic                  cmd_cd,
    input  logic                  cmd_last,
    output logic                  cmd_ready,
    output logic [LCD_DATA_W-1:0] lcd_data,
    output logic                  lcd_cd,
    output logic                  lcd_write,
    output logic                  busy
);

    localparam int unsigned RUN_W = $clog2(MAX_PX_BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_PX_BURST);

    logic [RUN_W-1:0] run;
    logic             lock;
    lcd_byte_t        bus_q;
    logic             idle;
    logic             grant_ok;
    logic             run_sat;
    logic             px_acc;
    logic             cmd_acc;

    // Arbitration: pixels win until the run saturates; a locked burst excludes pixels
    always_comb begin
        run_sat   = (run == RUN_MAX);
        grant_ok  = idle && !reset;
        px_ready  = grant_ok && !lock && !(cmd_valid && run_sat);
        cmd_ready = grant_ok && (lock || !px_valid || run_sat);
        px_acc    = px_valid && px_ready;
        cmd_acc   = cmd_valid && cmd_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_q <= '0;
            lock  <= 1'b0;
            run   <= '0;
        end else if (px_acc) begin
            bus_q <= '{cd: LCD_CD_DATA, data: px_data};
            if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
        end else if (cmd_acc) begin
            bus_q <= '{cd: cmd_cd, data: cmd_data};
            lock  <= !cmd_last;
            run   <= '0;
        end
    end

    lcd_bus_strobe #(
        .WR_ACTIVE (WR_ACTIVE),
        .WR_RECOVER(WR_RECOVER)
    ) u_strobe (
        .clk      (clk),
        .reset    (reset),
        .start    (px_acc || cmd_acc),
        .lcd_write(lcd_write),
        .idle     (idle)
    );

    assign lcd_data = bus_q.data;
    assign lcd_cd   = bus_q.cd;
    assign busy     = !idle;

endmodule

// File: tb/tb_lcd_bus_arb.sv
// Bench for lcd_bus_arb: cycle reference model built from byte-period arithmetic,
// directed scenarios plus a randomized requester mix, and a fast-strobe instance.
module tb_lcd_bus_arb;

    localparam int MAXB = 4;
    localparam int WA   = 1;
    localparam int WR   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       px_valid, cmd_valid, cmd_cd, cmd_last;
    logic [7:0] px_data, cmd_data;
    logic       px_ready, cmd_ready, lcd_cd, lcd_write, busy;
    logic [7:0] lcd_data;

    logic       px_valid_b, cmd_valid_b, cmd_cd_b, cmd_last_b;
    logic [7:0] px_data_b, cmd_data_b;
    logic       px_ready_b, cmd_ready_b, lcd_cd_b, lcd_write_b, busy_b;
    logic [7:0] lcd_data_b;

    always #5 clk = ~clk;

    lcd_bus_arb #(.WR_ACTIVE(WA), .WR_RECOVER(WR), .MAX_PX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_cd(cmd_cd),
        .cmd_last(cmd_last), .cmd_ready(cmd_ready),
        .lcd_data(lcd_data), .lcd_cd(lcd_cd), .lcd_write(lcd_write), .busy(busy)
    );

    lcd_bus_arb #(.WR_ACTIVE(2), .WR_RECOVER(0), .MAX_PX_BURST(MAXB)) dut_fast (
        .clk(clk), .reset(reset),
        .px_valid(px_valid_b), .px_data(px_data_b), .px_ready(px_ready_b),
        .cmd_valid(cmd_valid_b), .cmd_data(cmd_data_b), .cmd_cd(cmd_cd_b),
        .cmd_last(cmd_last_b), .cmd_ready(cmd_ready_b),
        .lcd_data(lcd_data_b), .lcd_cd(lcd_cd_b), .lcd_write(lcd_write_b), .busy(busy_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: cycle index since reset, time of last accept, next accept slot
    int         cyc, m_acc_t, m_next, m_run;
    logic       m_lock, m_cd, m_px_acc, m_cmd_acc;
    logic [7:0] m_data;
    logic [11:0] exp_v;
    logic [11:0] obs_v;
    assign obs_v = {px_ready, cmd_ready, lcd_write, busy, lcd_cd, lcd_data};

    task automatic model_reset();
        cyc = 0; m_acc_t = -100; m_next = 0; m_run = 0;
        m_lock = 1'b0; m_cd = 1'b0; m_data = 8'h00;
        m_px_acc = 1'b0; m_cmd_acc = 1'b0;
    endtask

    task automatic at_negedge();
        logic idl, sat, e_pxr, e_cmr, e_w;
        @(negedge clk);
        idl   = (cyc >= m_next);
        sat   = (m_run == MAXB);
        e_pxr = idl && !m_lock && !(cmd_valid && sat);
        e_cmr = idl && (m_lock || !px_valid || sat);
        e_w   = (cyc >= m_acc_t + 1) && (cyc <= m_acc_t + WA);
        exp_v = {e_pxr, e_cmr, e_w, !idl, m_cd, m_data};
        m_px_acc  = px_valid && e_pxr;
        m_cmd_acc = cmd_valid && e_cmr;
    endtask

    task automatic to_next();
        @(posedge clk);
        if (m_px_acc) begin
            m_data = px_data; m_cd = 1'b1;
            m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
            m_acc_t = cyc; m_next = cyc + 1 + WA + WR;
        end else if (m_cmd_acc) begin
            m_data = cmd_data; m_cd = cmd_cd;
            m_run = 0; m_lock = !cmd_last;
            m_acc_t = cyc; m_next = cyc + 1 + WA + WR;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        px_valid = 1'b1; px_data = 8'hFF; cmd_valid = 1'b1; cmd_data = 8'hFF;
        cmd_cd = 1'b1; cmd_last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_v !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_state: got %h want 000", obs_v);
            end
        end
        px_valid = 1'b0; cmd_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_single_pixel();
        px_valid = 1'b1; px_data = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            at_negedge();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL single_pixel cyc %0d: got %h want %h", c, obs_v, exp_v);
            end
            if (c == 1) begin
                n_cmp++;
                if ({lcd_write, lcd_cd, lcd_data} !== {2'b11, 8'h5A}) begin
                    n_fail++;
                    $display("FAIL single_pixel_strobe: got %b/%b/%h want 1/1/5a", lcd_write, lcd_cd, lcd_data);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({px_ready, lcd_write} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL single_pixel_ready_again: got %b want 10", {px_ready, lcd_write});
                end
            end
            to_next();
            if (m_px_acc) px_valid = 1'b0;
        end
    endtask

    task automatic test_single_cmd();
        cmd_valid = 1'b1; cmd_cd = 1'b0; cmd_data = 8'hE2; cmd_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            at_negedge();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL single_cmd cyc %0d: got %h want %h", c, obs_v, exp_v);
            end
            if (c == 1) begin
                n_cmp++;
                if ({lcd_write, lcd_cd, lcd_data} !== {2'b10, 8'hE2}) begin
                    n_fail++;
                    $display("FAIL single_cmd_bus: got %b/%b/%h want 1/0/e2", lcd_write, lcd_cd, lcd_data);
                end
            end
            to_next();
            if (m_cmd_acc) cmd_valid = 1'b0;
        end
    endtask

    task automatic test_burst();
        int t_c1, t_c2, t_p;
        t_c1 = -1; t_c2 = -1; t_p = -1;
        px_valid = 1'b1; px_data = $urandom;
        cmd_valid = 1'b1; cmd_cd = 1'b0; cmd_data = 8'h81; cmd_last = 1'b0;
        for (int c = 0; c < 24; c++) begin
            at_negedge();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL burst cyc %0d: got %h want %h", c, obs_v, exp_v);
            end
            if (cmd_valid && cmd_ready) begin
                if (t_c1 < 0) t_c1 = c; else t_c2 = c;
            end
            if (px_valid && px_ready && t_c1 >= 0 && t_p < 0) t_p = c;
            to_next();
            if (m_px_acc) px_data = $urandom;
            if (m_cmd_acc) begin
                if (cmd_last) cmd_valid = 1'b0;
                else begin cmd_data = 8'h46; cmd_last = 1'b1; end
            end
        end
        n_cmp++;
        if (t_c1 != 12 || t_c2 != t_c1 + 3 || t_p != t_c1 + 6) begin
            n_fail++;
            $display("FAIL burst_timing: got cmd %0d,%0d px %0d want 12,15 px 18", t_c1, t_c2, t_p);
        end
    endtask

    task automatic test_starvation();
        int n_px, tp6, tc1, tc2, px_between;
        n_px = 0; tp6 = -1; tc1 = -1; tc2 = -1; px_between = 0;
        px_valid = 1'b1; cmd_valid = 1'b0; cmd_cd = 1'b0; cmd_last = 1'b1; cmd_data = 8'hB0;
        for (int c = 0; c < 60; c++) begin
            at_negedge();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL starvation cyc %0d: got %h want %h", c, obs_v, exp_v);
            end
            if (px_valid && px_ready) begin
                n_px++;
                if (n_px == 6) tp6 = c;
                if (tc1 >= 0 && tc2 < 0) px_between++;
            end
            if (cmd_valid && cmd_ready) begin
                if (tc1 < 0) tc1 = c; else if (tc2 < 0) tc2 = c;
            end
            to_next();
            if (m_px_acc) px_data = $urandom;
            if (n_px == 6 && tc1 < 0) cmd_valid = 1'b1;
            if (m_cmd_acc) begin
                if (tc2 < 0) cmd_data = 8'hB1; else cmd_valid = 1'b0;
            end
        end
        n_cmp++;
        if (tp6 < 0 || tc1 != tp6 + 3 || px_between != 4 || tc2 != tc1 + 15) begin
            n_fail++;
            $display("FAIL starvation_bound: got px6 %0d cmd %0d,%0d between %0d want cmd px6+3, +15, 4 between",
                     tp6, tc1, tc2, px_between);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic got;
        got = 1'b0;
        px_valid = 1'b0;
        cmd_valid = 1'b1; cmd_cd = 1'b0; cmd_data = 8'h81; cmd_last = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            at_negedge();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc %0d: got %h want %h", c, obs_v, exp_v);
            end
            to_next();
            got = m_cmd_acc;
        end
        n_cmp++;
        if (!got || lcd_write !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_strobe_seen: accepted %b write %b want 1 1", got, lcd_write);
        end
        px_valid = 1'b1; cmd_valid = 1'b1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({lcd_write, busy, px_ready, cmd_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_truncate: got %b want 0000", {lcd_write, busy, px_ready, cmd_ready});
        end
        @(negedge clk);
        px_valid = 1'b0; cmd_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        px_valid = 1'b1; px_data = 8'h33;
        at_negedge();
        n_cmp++;
        if (obs_v !== exp_v || px_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_unlock: got %h want %h", obs_v, exp_v);
        end
        to_next();
        if (m_px_acc) px_valid = 1'b0;
    endtask

    task automatic test_random();
        int burst_rem;
        burst_rem = 0;
        for (int c = 0; c < 600; c++) begin
            if (!px_valid && $urandom_range(0, 3) != 0) begin
                px_valid = 1'b1; px_data = $urandom;
            end
            if (!cmd_valid) begin
                if (burst_rem == 0 && $urandom_range(0, 9) == 0) burst_rem = $urandom_range(1, 3);
                if (burst_rem != 0 && $urandom_range(0, 1) == 0) begin
                    cmd_valid = 1'b1; cmd_data = $urandom; cmd_cd = $urandom;
                    cmd_last = (burst_rem == 1);
                end
            end
            at_negedge();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", c, obs_v, exp_v);
            end
            to_next();
            if (m_px_acc) px_valid = 1'b0;
            if (m_cmd_acc) begin cmd_valid = 1'b0; burst_rem--; end
        end
        px_valid = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_fast_strobe();
        int n_acc;
        logic [3:0] e, o;
        n_acc = 0;
        px_valid_b = 1'b1; px_data_b = 8'hA5;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            e = {(k % 3 != 0), (k % 3 == 0), (k % 3 != 0), 1'b0};
            o = {lcd_write_b, px_ready_b, busy_b, cmd_ready_b};
            n_cmp++;
            if (o !== e || (k >= 1 && {lcd_cd_b, lcd_data_b} !== 9'h1A5)) begin
                n_fail++;
                $display("FAIL fast_strobe k %0d: got %b %b/%h want %b 1/a5", k, o, lcd_cd_b, lcd_data_b, e);
            end
            if (px_valid_b && px_ready_b) n_acc++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n_acc != 4) begin
            n_fail++;
            $display("FAIL fast_strobe_rate: got %0d bytes want 4", n_acc);
        end
        px_valid_b = 1'b0;
    endtask

    initial begin
        px_valid_b = 1'b0; px_data_b = 8'h00; cmd_valid_b = 1'b0;
        cmd_data_b = 8'h00; cmd_cd_b = 1'b0; cmd_last_b = 1'b0;
        model_reset();
        test_reset();
        test_single_pixel();
        test_single_cmd();
        test_burst();
        test_starvation();
        test_reset_mid_burst();
        test_random();
        test_fast_strobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arb.md
# lcd_bus_arb

Arbiter and write-strobe sequencer for the 8-bit parallel LCD controller bus (UC1611-class, write-only, active-high `lcd_write` strobe). It shares one bus between a pixel-stream requester (2-pixel bytes, `cd=1`) and a command requester (init, address, contrast bursts) and owns all bus timing. Command bursts are atomic, and a saturating run counter bounds command starvation. The block sits between the LCD pixel/command producers and the LCD pins.

## Interface
- `WR_ACTIVE`, default 1: cycles `lcd_write` stays high per byte (≥1).
- `WR_RECOVER`, default 1: cycles `lcd_write` stays low after the strobe before the next accept (≥0).
- `MAX_PX_BURST`, default 16: pixel bytes accepted since the last command byte, after which a pending command wins (≥1).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `px_valid` in 1: pixel byte available.
- `px_data` in 8: pixel byte.
- `px_ready` out 1: pixel byte accepted this cycle when `px_valid` is also high.
- `cmd_valid` in 1: command byte available.
- `cmd_data` in 8: command byte.
- `cmd_cd` in 1: value driven on `lcd_cd` for this byte.
- `cmd_last` in 1: last byte of an atomic burst.
- `cmd_ready` out 1: command byte accepted this cycle when `cmd_valid` is also high.
- `lcd_data` out 8: bus data.
- `lcd_cd` out 1: 0 = command, 1 = data.
- `lcd_write` out 1: write strobe, active-high.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: accept cycle.
  - STROBE: `WR_ACTIVE` cycles.
  - RECOVER: `WR_RECOVER` cycles, skipped when 0.
- Transitions:
  - IDLE→STROBE on any accept.
  - STROBE→RECOVER, or →IDLE when `WR_RECOVER=0`, after the counter expires.
  - RECOVER→IDLE after the counter expires.
- Handshake: a byte is accepted when `valid && ready`. Requesters hold valid and data stable until accepted. Readies are low outside IDLE.
- Arbitration in IDLE:
  - `lock=1`: `cmd_ready=1`, `px_ready=0`.
  - Otherwise `px_ready = !(cmd_valid && run==MAX_PX_BURST)` and `cmd_ready = !px_valid || run==MAX_PX_BURST`.
  - Pixel wins ties until `run` saturates.
  - Both readies are combinational on the other requester's valid. Valids must not depend on readies.
- On accept: register `lcd_data` (`px_data` or `cmd_data`) and `lcd_cd` (1 for pixel, `cmd_cd` for command). Both hold until the next accept.
- `run` counter (width `$clog2(MAX_PX_BURST+1)`):
  - +1 on each pixel accept, saturating at `MAX_PX_BURST`.
  - Cleared on each command accept.
- `lock`: set on accepting a command byte with `cmd_last=0`; cleared on accepting one with `cmd_last=1`. A pixel requester is never granted mid-burst.
- Simultaneous valids while locked: only the command requester is served. A pixel requester waits indefinitely during a burst.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `lcd_write=0`, `lcd_data=0`, `lcd_cd=0`, `lock=0`, `run=0`, `busy=0`. Readies are 0 while `reset` is high.
- Reset mid-strobe truncates the strobe immediately. The byte is lost and no partial burst lock survives.
- Accept at cycle t:
  - `lcd_data`/`lcd_cd` valid from t+1.
  - `lcd_write` high at t+1..t+WR_ACTIVE.
  - Low for `WR_RECOVER` cycles.
  - Next accept possible at t+1+WR_ACTIVE+WR_RECOVER.
- Byte period is 1+WR_ACTIVE+WR_RECOVER cycles. Defaults give 3 cycles per byte.
- Data and cd are stable for the whole strobe plus recovery.

## Structure
- Shared package `lcd_pkg`: state enum (IDLE/STROBE/RECOVER) and the `LCD_CD_CMD=0` / `LCD_CD_DATA=1` constants.
- Sub-module `lcd_bus_strobe`: the STROBE/RECOVER counter. Inputs: `start`. Outputs: `lcd_write`, `idle`. Parameterised by `WR_ACTIVE`/`WR_RECOVER`.
- The top level holds the arbitration, `lock`, `run`, and the data/cd registers.

## Test plan
Defaults unless noted; `MAX_PX_BURST=4`.
- Single pixel `0x5A` accepted at cycle 0 → `lcd_data=0x5A`, `lcd_cd=1` from cycle 1; `lcd_write` high cycle 1, low cycle 2; `px_ready` high again cycle 3.
- `cmd_valid` with `cmd_cd=0`, `0xE2`, `cmd_last=1`, no pixels → `lcd_cd=0`, `lcd_data=0xE2`, one strobe, `lock` stays 0.
- `px_valid` held high, command burst `0x81` (`last=0`), `0x46` (`last=1`) → once granted, both bytes go back to back at cycles t and t+3 with no pixel between; pixels resume at t+6.
- `px_valid` continuous, `cmd_valid` raised after 6 pixels (`run` saturated) → command accepted at the next IDLE. A second command pending immediately afterwards → exactly 4 pixel bytes, then the command.
- `reset` pulsed during `lcd_write=1` of a burst's first byte → `lcd_write=0` at once, `busy=0`, `lock=0`; after release a pixel is granted even though `cmd_last` was never seen.
- `WR_ACTIVE=2`, `WR_RECOVER=0`, continuous pixels → `lcd_write` pattern 0,1,1 repeating; one byte every 3 cycles.
